// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register for an inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries packed data channels, a control bundle and a valid bit. Stall holds
// the stage and flush inserts a bubble. Two saturating counters record stalled
// cycles and bubbles for hazard-unit debug.
module pipe_stage_buf #(
  parameter int DATA_W   = 16,
  parameter int NUM_DATA = 2,
  parameter int CTRL_W   = 2,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       cnt_clr,
  input  logic                       valid_in,
  input  logic [NUM_DATA*DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0]          ctrl_in,
  output logic                       valid_out,
  output logic [NUM_DATA*DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0]          ctrl_out,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic stall_evt;
  logic bubble_evt;

  // Hazard events, decoded from the values present before the edge
  always_comb begin
    stall_evt  = stall & ~flush & valid_out;
    bubble_evt = flush | (~stall & ~valid_in);
  end

  // Stage register: flush clears valid/ctrl but keeps data; stall holds everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      ctrl_out  <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
      ctrl_out  <= '0;
    end else if (!stall) begin
      valid_out <= valid_in;
      data_out  <= data_in;
      // An invalid load is a bubble: control is forced low so that
      // valid_out=0 always implies ctrl_out=0
      ctrl_out  <= valid_in ? ctrl_in : '0;
    end
  end

  // Saturating count of cycles spent holding a valid instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // Saturating count of bubbles entering the stage (flush or invalid load)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (bubble_evt && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf. Two instances share the
// same stimulus: one with default parameters, one with 2-bit counters so
// saturation is reached quickly.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        cnt_clr;
  logic        valid_in;
  logic [31:0] data_in;
  logic [1:0]  ctrl_in;

  logic        valid_out, valid_out_s;
  logic [31:0] data_out, data_out_s;
  logic [1:0]  ctrl_out, ctrl_out_s;
  logic [7:0]  stall_cnt, bubble_cnt;
  logic [1:0]  stall_cnt_s, bubble_cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_buf u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ctrl_in    (ctrl_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .ctrl_out   (ctrl_out),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_buf #(.CNT_W(2)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .cnt_clr    (cnt_clr),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ctrl_in    (ctrl_in),
    .valid_out  (valid_out_s),
    .data_out   (data_out_s),
    .ctrl_out   (ctrl_out_s),
    .stall_cnt  (stall_cnt_s),
    .bubble_cnt (bubble_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Datapath of both instances against one expectation
  task automatic chk_path(input string tag, input logic v, input logic [31:0] d, input logic [1:0] c);
    chk({tag, ".valid"},   32'(valid_out),   32'(v));
    chk({tag, ".data"},    data_out,         d);
    chk({tag, ".ctrl"},    32'(ctrl_out),    32'(c));
    chk({tag, ".valid_s"}, 32'(valid_out_s), 32'(v));
    chk({tag, ".data_s"},  data_out_s,       d);
    chk({tag, ".ctrl_s"},  32'(ctrl_out_s),  32'(c));
  endtask

  // Counters: wide instance and 2-bit instance have separate expectations
  task automatic chk_cnt(input string tag, input int sw, input int bw, input int ss, input int bs);
    chk({tag, ".stall_cnt"},    32'(stall_cnt),    32'(sw));
    chk({tag, ".bubble_cnt"},   32'(bubble_cnt),   32'(bw));
    chk({tag, ".stall_cnt_s"},  32'(stall_cnt_s),  32'(ss));
    chk({tag, ".bubble_cnt_s"}, 32'(bubble_cnt_s), 32'(bs));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    valid_in = 1'b1; data_in = 32'hBEEF_1234; ctrl_in = 2'b11;
    #2;
    chk_path("reset", 1'b0, 32'h0, 2'b00);
    chk_cnt("reset", 0, 0, 0, 0);
    #1 rst = 1'b0;

    // Load, then asynchronous reset between edges
    step;
    chk_path("pre_rst_load", 1'b1, 32'hBEEF_1234, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk_path("async_rst", 1'b0, 32'h0, 2'b00);
    chk_cnt("async_rst", 0, 0, 0, 0);
    rst = 1'b0;

    // Plain load
    valid_in = 1'b1; data_in = {16'hAAAA, 16'h5555}; ctrl_in = 2'b10;
    step;
    chk_path("load", 1'b1, 32'hAAAA_5555, 2'b10);
    chk_cnt("load", 0, 0, 0, 0);

    // Stall a valid stage for 3 edges while inputs change
    stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      valid_in = i[0]; data_in = 32'h1111_1111 * i; ctrl_in = 2'(i);
      step;
      chk_path("stall", 1'b1, 32'hAAAA_5555, 2'b10);
      chk_cnt("stall", i, 0, i, 0);
    end

    // Flush and stall together: flush wins, data kept
    flush = 1'b1; valid_in = 1'b1; data_in = 32'h0F0F_0F0F; ctrl_in = 2'b11;
    step;
    chk_path("flush_stall", 1'b0, 32'hAAAA_5555, 2'b00);
    chk_cnt("flush_stall", 3, 1, 3, 1);

    // Stalling an empty stage is not counted
    flush = 1'b0;
    step;
    chk_path("stall_empty", 1'b0, 32'hAAAA_5555, 2'b00);
    chk_cnt("stall_empty", 3, 1, 3, 1);

    // Bubble load: ctrl forced to zero, data still loaded
    stall = 1'b0; valid_in = 1'b0; ctrl_in = 2'b11; data_in = 32'h1234_5678;
    step;
    chk_path("bubble_load", 1'b0, 32'h1234_5678, 2'b00);
    chk_cnt("bubble_load", 3, 2, 3, 2);

    // Clear counters while loading: datapath unaffected
    cnt_clr = 1'b1; valid_in = 1'b1; data_in = 32'h1111_2222; ctrl_in = 2'b01;
    step;
    chk_path("clr_load", 1'b1, 32'h1111_2222, 2'b01);
    chk_cnt("clr_load", 0, 0, 0, 0);
    cnt_clr = 1'b0;

    // Five stalled-valid cycles: 2-bit counter saturates at 3
    stall = 1'b1; data_in = 32'hDEAD_BEEF; ctrl_in = 2'b10;
    for (int i = 1; i <= 5; i++) begin
      step;
      chk_cnt("stall_sat", i, 0, (i > 3) ? 3 : i, 0);
    end
    chk_path("stall_sat", 1'b1, 32'h1111_2222, 2'b01);

    // Clear with stall: clear wins over increment
    cnt_clr = 1'b1;
    step;
    chk_cnt("clr_stall", 0, 0, 0, 0);
    chk_path("clr_stall", 1'b1, 32'h1111_2222, 2'b01);
    cnt_clr = 1'b0;
    step;
    chk_cnt("post_clr", 1, 0, 1, 0);

    // Repeated flushes: bubble counter saturates, stall counter idle
    flush = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step;
      chk_cnt("bubble_sat", 1, i, 1, (i > 3) ? 3 : i);
    end
    chk_path("bubble_sat", 1'b0, 32'h1111_2222, 2'b00);

    // Input changes between edges do not reach the outputs
    flush = 1'b0; stall = 1'b0; valid_in = 1'b1; data_in = 32'hCAFE_F00D; ctrl_in = 2'b11;
    #2;
    chk_path("no_comb", 1'b0, 32'h1111_2222, 2'b00);
    step;
    chk_path("reload", 1'b1, 32'hCAFE_F00D, 2'b11);
    chk_cnt("reload", 1, 4, 1, 3);

    // Asynchronous reset clears non-zero counters
    #2 rst = 1'b1;
    #1;
    chk_path("final_rst", 1'b0, 32'h0, 2'b00);
    chk_cnt("final_rst", 0, 0, 0, 0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline-stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries NUM_DATA data channels of DATA_W bits, a CTRL_W control bundle and a valid bit.
- Stall holds the stage; flush inserts a bubble.
- Saturating stall and bubble counters provide hazard-unit debug and performance visibility.

Parameters:
DATA_W, 16, width of each data channel
NUM_DATA, 2, number of data channels (packed, channel 0 in LSBs)
CTRL_W, 2, width of control bundle (e.g. writeReg, regSel)
CNT_W, 8, width of each saturating event counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous reset, active-high
stall  input  1  hold current contents
flush  input  1  insert bubble (overrides stall)
cnt_clr  input  1  synchronous clear of both counters
valid_in  input  1  upstream stage holds a real instruction
data_in  input  NUM_DATA*DATA_W  upstream data channels
ctrl_in  input  CTRL_W  upstream control bundle
valid_out  output  1  registered valid
data_out  output  NUM_DATA*DATA_W  registered data channels
ctrl_out  output  CTRL_W  registered control bundle
stall_cnt  output  CNT_W  cycles held with valid content
bubble_cnt  output  CNT_W  bubbles entered into stage

Behaviour:
- Single clock (clk); reset rst is asynchronous, active-high.
- Reset: valid_out=0, data_out=0, ctrl_out=0, stall_cnt=0, bubble_cnt=0. Assertion mid-operation clears all state immediately, without waiting for a clock edge.
- Latency: 1 cycle; outputs are registered only, with no combinational path from input to output.
- Per-edge priority, rst > flush > stall > load:
  - flush=1: valid_out<=0, ctrl_out<=0, data_out holds its previous value. Applies regardless of stall.
  - flush=0, stall=1: all of valid_out, data_out and ctrl_out hold.
  - flush=0, stall=0: valid_out<=valid_in, data_out<=data_in, ctrl_out<=ctrl_in.
  - When loading with valid_in=0, ctrl_out<=0 (bubble) and data_out<=data_in.
- Invariant: valid_out=0 implies ctrl_out=0 at all times after reset.
- stall_cnt increments when stall=1, flush=0 and valid_out=1. Stalling an empty stage is not counted.
- bubble_cnt increments when either:
  - flush=1, or
  - flush=0, stall=0 and valid_in=0.
  - At most +1 per cycle.
- Both counters saturate at 2^CNT_W-1 and do not wrap.
- cnt_clr=1 sets both counters to 0 on the edge and takes priority over increment. It does not affect the data path.
- Counter updates use pre-edge values of valid_out, stall, flush and valid_in.
- Width rules:
  - Channel k occupies bits [k*DATA_W +: DATA_W].
  - NUM_DATA, DATA_W, CTRL_W and CNT_W must each be >= 1.
  - Counters use unsigned arithmetic.

Test Plan:
- Reset mid-operation: load data_in=0xBEEF_1234, ctrl_in=2'b11, valid_in=1; assert rst between edges -> all outputs read 0 before the next clk edge.
- Load: valid_in=1, data_in={16'hAAAA,16'h5555}, ctrl_in=2'b10, stall=0 -> one edge later valid_out=1, data_out=0xAAAA5555, ctrl_out=2'b10, bubble_cnt=0.
- Stall: with the stage holding valid content, hold stall=1 for 3 edges while data_in changes every cycle -> outputs unchanged, stall_cnt=3. Stall with valid_out=0 -> stall_cnt unchanged.
- Flush with stall: flush=1 and stall=1 on the same edge -> valid_out=0, ctrl_out=0, data_out unchanged, bubble_cnt +1, stall_cnt unchanged.
- Bubble load: valid_in=0, ctrl_in=2'b11, data_in=0x12345678 -> valid_out=0, ctrl_out=0, data_out=0x12345678, bubble_cnt +1.
- Saturation and clear (CNT_W=2): 5 stalled-valid cycles -> stall_cnt=3 (held, no wrap). Then assert cnt_clr together with stall -> stall_cnt=0 after the edge.
